imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
Boot sequencer and port owner for the single-cycle core's instruction memory. On request it clears the whole instruction ROM/RAM to NOPs and streams a program in over a valid/ready word interface. It then releases the core and routes core fetches to the memory read port. While not running it holds the core stopped and feeds it NOPs, so the core never fetches a half-loaded program.

Parameters:
ADDR_WIDTH, 32, width of byte addresses (fetch PC, memory addresses)
DATA_WIDTH, 32, instruction/word width
ROM_SIZE, 30, memory depth in words; localparam IDX_W = $clog2(ROM_SIZE+1)

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
load_start_i  in  1  request (re)load; sampled in IDLE, RUN, ERR only
ld_valid_i  in  1  loader word valid
ld_data_i  in  DATA_WIDTH  loader word
ld_last_i  in  1  marks final program word (qualified by valid&&ready)
ld_ready_o  out  1  controller accepts a word this cycle
mem_we_o  out  1  memory write enable (synchronous write)
mem_waddr_o  out  ADDR_WIDTH  byte write address (word index*4)
mem_wdata_o  out  DATA_WIDTH  write data
mem_raddr_o  out  ADDR_WIDTH  byte read address (async read port)
mem_rdata_i  in  DATA_WIDTH  read data
core_pc_i  in  ADDR_WIDTH  core fetch byte address
core_instr_o  out  DATA_WIDTH  instruction to core
core_run_o  out  1  core may execute (core held in reset while 0)
busy_o  out  1  high in CLEAR/LOAD(/CSUM)
err_o  out  1  high in ERR
fetch_fault_o  out  1  sticky: misaligned or out-of-range fetch seen in RUN
words_loaded_o  out  IDX_W  program words accepted in last load

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0; core_run_o, ld_ready_o, mem_we_o, busy_o, err_o, fetch_fault_o = 0; words_loaded_o = 0.
- NOP constant = 32'h0000_0013. Outside RUN: core_instr_o = NOP, mem_raddr_o = 0.
- IDLE: load_start_i -> CLEAR, idx=0.
- CLEAR: mem_we_o=1, waddr=idx*4, wdata=NOP, idx++ each cycle. Lasts exactly ROM_SIZE cycles; after the write at idx=ROM_SIZE-1 -> LOAD, idx=0. ld_ready_o=0.
- LOAD: ld_ready_o=1. A transfer is valid&&ready; the same cycle sees mem_we_o=1, waddr=idx*4, wdata=ld_data_i, then idx++. No write without a transfer.
- LOAD exit on a transfer with ld_last_i: words_loaded_o=idx+1, next state RUN (or CSUM with the feature enabled).
- LOAD overflow: a transfer at idx=ROM_SIZE-1 without ld_last_i writes the word, then -> ERR.
- RUN: core_run_o=1 (registered; first high cycle is the cycle after entry); mem_raddr_o=core_pc_i; core_instr_o=mem_rdata_i. Zero-latency combinational fetch path.
- RUN fetch fault: core_pc_i[1:0]!=0 or core_pc_i/4 >= ROM_SIZE -> core_instr_o=NOP, fetch_fault_o set next cycle; it clears only on reset or load_start_i.
- RUN with load_start_i -> CLEAR; core_run_o low from the next cycle; fetch_fault_o cleared.
- ERR: err_o=1, core_run_o=0; exits only via load_start_i -> CLEAR.
- load_start_i during CLEAR/LOAD/CSUM: ignored. ld_valid_i outside LOAD: ignored, never written.
- Reset mid-load: immediate IDLE; memory keeps partial contents; core stays stopped until a full load completes.

Optional Feature:
IMEM_BOOT_CHECKSUM_EN
- Defined: a 32-bit wrapping sum of all accepted program words is kept.
- After the ld_last_i transfer, state CSUM: ld_ready_o=1, one trailer word accepted and not written to memory.
- Trailer equal to the sum -> RUN; otherwise -> ERR.
- Undefined: no CSUM state; LOAD exits directly to RUN.

Decomposition:
- Package imem_boot_pkg: state enum (IDLE, CLEAR, LOAD, CSUM, RUN, ERR), NOP_INSTR constant, word-to-byte address helper function.
- One sub-module: imem_csum_acc (clear, add-enable, data in, sum out), instantiated only under the macro.

Test Plan:
- Reset, then load_start_i pulse -> 30 consecutive mem_we_o cycles, waddr 0x00..0x74, wdata 0x00000013; busy_o=1 throughout.
- LOAD of 3 words 0x00100093, 0x00200113, 0x002081B3 (last on third), with ld_valid_i gapped -> exactly 3 writes at 0x0, 0x4, 0x8; words_loaded_o=3; core_run_o=1 one cycle after the last transfer.
- RUN, core_pc_i=0x8 -> core_instr_o=0x002081B3; core_pc_i=0x6 or 0x78 -> NOP, fetch_fault_o=1 next cycle.
- 30 words without ld_last_i -> 30 writes, err_o=1, core_run_o=0; load_start_i recovers to CLEAR.
- rst_n low mid-LOAD (idx=2) -> all outputs reset immediately, state IDLE, no further writes.
- With IMEM_BOOT_CHECKSUM_EN, words 1, 2, 3 followed by trailer 6 -> RUN; trailer 7 -> ERR; the trailer is never written to memory.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] word2byte(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_csum_acc.sv
// Wrapping sum of accepted program words, cleared when a new load starts.
module imem_csum_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         add_en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sum_o <= '0;
    else if (clr_i)    sum_o <= '0;
    else if (add_en_i) sum_o <= sum_o + data_i;
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer owning the instruction memory: clear to NOPs, stream a program in, then run the core.
// Optional trailer checksum check when IMEM_BOOT_CHECKSUM_EN is defined.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_SIZE   = 30,
  localparam int IDX_W     = $clog2(ROM_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start_i,
  input  logic                  ld_valid_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [ADDR_WIDTH-1:0] core_pc_i,
  output logic [DATA_WIDTH-1:0] core_instr_o,
  output logic                  core_run_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  fetch_fault_o,
  output logic [IDX_W-1:0]      words_loaded_o
);

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(ROM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ROM_BYTES = ADDR_WIDTH'(ROM_SIZE * 4);
  localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(NOP_INSTR);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             fetch_fault_q;
  logic [IDX_W-1:0] words_q;

  logic running, start, pc_bad;

  assign running = (state == S_RUN);
  assign start   = load_start_i && (state == S_IDLE || state == S_RUN || state == S_ERR);
  assign pc_bad  = (core_pc_i[1:0] != 2'b00) || (core_pc_i >= ROM_BYTES);

  assign ld_ready_o     = (state == S_LOAD) || (state == S_CSUM);
  assign busy_o         = (state == S_CLEAR) || ld_ready_o;
  assign err_o          = (state == S_ERR);
  assign core_run_o     = running;
  assign fetch_fault_o  = fetch_fault_q;
  assign words_loaded_o = words_q;

  // Trailer words in CSUM are consumed but never reach memory.
  assign mem_we_o    = (state == S_CLEAR) || (state == S_LOAD && ld_valid_i);
  assign mem_waddr_o = ADDR_WIDTH'(word2byte(32'(idx)));
  assign mem_wdata_o = (state == S_CLEAR) ? NOP : ld_data_i;

  // Fetch path is purely combinational so the core sees zero-latency instruction memory.
  assign mem_raddr_o  = running ? core_pc_i : '0;
  assign core_instr_o = (running && !pc_bad) ? mem_rdata_i : NOP;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;

  imem_csum_acc #(.W(DATA_WIDTH)) u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (start),
    .add_en_i (state == S_LOAD && ld_valid_i),
    .data_i   (ld_data_i),
    .sum_o    (csum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      fetch_fault_q <= 1'b0;
      words_q       <= '0;
    end else begin
      if (start)                  fetch_fault_q <= 1'b0;
      else if (running && pc_bad) fetch_fault_q <= 1'b1;

      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (load_start_i) begin
            state <= S_CLEAR;
            idx   <= '0;
          end
        end
        S_CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= S_LOAD;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_valid_i) begin
            idx <= idx + 1'b1;
            if (ld_last_i) begin
              words_q <= idx + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
              state   <= S_CSUM;
`else
              state   <= S_RUN;
`endif
            end else if (idx == LAST_IDX) begin
              state <= S_ERR;
            end
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CSUM: begin
          if (ld_valid_i) state <= (ld_data_i == csum) ? S_RUN : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected memory writes are queued by stimulus and popped by a monitor.
module tb_imem_boot_ctrl;

  localparam int RS = 30;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        load_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_data = '0, core_pc = '0;
  logic        ld_ready_o, mem_we_o, core_run_o, busy_o, err_o, fetch_fault_o;
  logic [31:0] mem_waddr_o, mem_wdata_o, mem_raddr_o, mem_rdata_i, core_instr_o;
  logic [4:0]  words_loaded_o;

  always #5 clk = ~clk;

  imem_boot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ld_ready_o),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .core_pc_i(core_pc), .core_instr_o(core_instr_o), .core_run_o(core_run_o),
    .busy_o(busy_o), .err_o(err_o), .fetch_fault_o(fetch_fault_o), .words_loaded_o(words_loaded_o)
  );

  // Environment RAM written by the DUT, read asynchronously.
  logic [31:0] ram [RS];
  always @(posedge clk) if (mem_we_o && mem_waddr_o < RS * 4) ram[int'(mem_waddr_o >> 2)] <= mem_wdata_o;
  assign mem_rdata_i = (mem_raddr_o < RS * 4) ? ram[int'(mem_raddr_o >> 2)] : 32'hDEAD_BEEF;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] ref_mem [RS];
  logic [31:0] prog [RS];
  int          n_tests = 0, n_fail = 0;
  bit          exp_fault = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we_o) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_waddr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {32'h0, mem_waddr_o}, {32'h0, e.a});
        chk("wr_data", {32'h0, mem_wdata_o}, {32'h0, e.d});
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_load();
    int cnt;
    load_start = 1'b1;
    for (int i = 0; i < RS; i++) begin
      exp_q.push_back('{a: i * 4, d: NOP});
      ref_mem[i] = NOP;
    end
    cyc();
    load_start = 1'b0;
    exp_fault  = 1'b0;
    @(negedge clk);
    chk("run_low_in_clear", core_run_o, 0);
    chk("fault_cleared", fetch_fault_o, 0);
    chk("instr_nop_clear", core_instr_o, NOP);
    chk("raddr_zero_clear", mem_raddr_o, 0);
    chk("busy_clear", busy_o, 1);
    cnt = 1;
    while (!ld_ready_o && cnt < 40) begin
      @(negedge clk);
      if (!ld_ready_o) cnt++;
    end
    chk("clear_cycles", cnt, RS);
    cyc();
  endtask

  task automatic send_words(input int n, input bit last, output logic [31:0] sum);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin ld_data = $urandom; cyc(); end
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = last && (i == n - 1);
      exp_q.push_back('{a: i * 4, d: prog[i]});
      ref_mem[i] = prog[i];
      sum += prog[i];
      @(negedge clk);
      chk("ld_ready", ld_ready_o, 1);
      if (i == n - 1) chk("run_before_done", core_run_o, 0);
      cyc();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
    end
  endtask

  task automatic do_load(input int n, input bit last, input bit bad_sum);
    logic [31:0] sum;
    bit          exp_err;
    exp_err = !last || (CSUM_ON && bad_sum);
    start_load();
    send_words(n, last, sum);
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (last) begin
      ld_valid = 1'b1;
      ld_data  = bad_sum ? sum + 32'd1 : sum;
      @(negedge clk);
      chk("csum_ready", ld_ready_o, 1);
      chk("trailer_not_written", mem_we_o, 0);
      cyc();
      ld_valid = 1'b0;
    end
`endif
    @(negedge clk);
    chk("run_after_load", core_run_o, !exp_err);
    chk("err_after_load", err_o, exp_err);
    chk("busy_after_load", busy_o, 0);
    chk("ready_after_load", ld_ready_o, 0);
    if (last) chk("words_loaded", words_loaded_o, n);
    cyc();
  endtask

  task automatic fetch_chk(input logic [31:0] pc, input bit running);
    bit bad;
    core_pc = pc;
    bad = (pc[1:0] != 2'b00) || (pc >= RS * 4);
    @(negedge clk);
    chk("instr", core_instr_o, (running && !bad) ? ref_mem[int'(pc >> 2)] : NOP);
    chk("raddr", mem_raddr_o, running ? pc : 32'h0);
    chk("fault_sticky", fetch_fault_o, exp_fault);
    if (running && bad) exp_fault = 1'b1;
    cyc();
  endtask

  task automatic rand_fetches(input int n, input bit running);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0:       pc = ($urandom_range(0, RS - 1) * 4) | $urandom_range(1, 3);
        1:       pc = $urandom_range(RS, 200) * 4;
        default: pc = $urandom_range(0, RS - 1) * 4;
      endcase
      fetch_fct: fetch_chk(pc, running);
    end
    core_pc = '0;
  endtask

  task automatic rand_prog(input int n);
    for (int i = 0; i < n; i++) prog[i] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_run", core_run_o, 0);
    chk("rst_ready", ld_ready_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fault", fetch_fault_o, 0);
    chk("rst_words", words_loaded_o, 0);
    chk("rst_instr", core_instr_o, NOP);
    cyc();
    rst_n = 1'b1;
    // Loader traffic in IDLE must be ignored.
    ld_valid = 1'b1;
    repeat (3) begin
      ld_data = $urandom;
      @(negedge clk);
      chk("idle_ready", ld_ready_o, 0);
      cyc();
    end
    ld_valid = 1'b0;

    prog[0] = 32'h0010_0093; prog[1] = 32'h0020_0113; prog[2] = 32'h0020_81B3;
    do_load(3, 1'b1, 1'b0);
    fetch_chk(32'h8, 1'b1);
    fetch_chk(32'h0, 1'b1);
    fetch_chk(32'h6, 1'b1);
    fetch_chk(32'h78, 1'b1);
    fetch_chk(32'h4, 1'b1);

    repeat (4) begin
      int n;
      n = $urandom_range(1, RS);
      rand_prog(n);
      do_load(n, 1'b1, 1'b0);
      rand_fetches(20, 1'b1);
    end

    rand_prog(RS);
    do_load(RS, 1'b0, 1'b0);
    rand_fetches(6, 1'b0);
    rand_prog(5);
    do_load(5, 1'b1, 1'b0);
    rand_fetches(10, 1'b1);

`ifdef IMEM_BOOT_CHECKSUM_EN
    prog[0] = 32'd1; prog[1] = 32'd2; prog[2] = 32'd3;
    do_load(3, 1'b1, 1'b1);
    rand_fetches(4, 1'b0);
    do_load(3, 1'b1, 1'b0);
    rand_fetches(4, 1'b1);
`endif

    rand_prog(4);
    start_load();
    send_words(2, 1'b0, s);
    ld_valid = 1'b1;
    ld_data  = $urandom;
    rst_n    = 1'b0;
    #1;
    chk("midrst_we", mem_we_o, 0);
    chk("midrst_ready", ld_ready_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_run", core_run_o, 0);
    chk("midrst_words", words_loaded_o, 0);
    exp_fault = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (3) begin
      ld_data = $urandom;
      @(negedge clk);
      chk("postrst_run", core_run_o, 0);
      chk("postrst_busy", busy_o, 0);
      cyc();
    end
    ld_valid = 1'b0;

    rand_prog(7);
    do_load(7, 1'b1, 1'b0);
    rand_fetches(10, 1'b1);

    repeat (2) cyc();
    chk("pending_writes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
